ascon_perm_core: RTL and testbench

Parametrised Ascon permutation engine implementing p^a with the official constant-addition, 5-bit S-box and linear-diffusion layers. It runs UNROLL rounds per clock and supports any legal round count from 1 to 12, including p12, p8 and p6. Valid/ready handshakes on input and output let it sit between the AEAD mode controller and the state register file, replacing the fixed single-round permutation.

---
 rtl/ascon_pkg.sv | 41 ++++
 rtl/ascon_round_comb.sv | 40 ++++
 rtl/ascon_perm_core.sv | 105 ++++++++++
 tb/tb_ascon_perm_core.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/ascon_pkg.sv
// Shared types, round constants and helpers for the Ascon permutation core.
package ascon_pkg;

  typedef struct packed {
    logic [63:0] x0;
    logic [63:0] x1;
    logic [63:0] x2;
    logic [63:0] x3;
    logic [63:0] x4;
  } ascon_state_t;

  localparam logic [7:0] ROUND_CONST [0:11] = '{
    8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
    8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b
  };

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fsm_state_t;

  function automatic ascon_state_t unpack_state(input logic [319:0] v);
    return ascon_state_t'(v);
  endfunction

  function automatic logic [319:0] pack_state(input ascon_state_t s);
    return {s.x0, s.x1, s.x2, s.x3, s.x4};
  endfunction

  // Indices past the last round (ri==12 while idle/done) read as zero.
  function automatic logic [7:0] round_const(input logic [3:0] ri);
    if (ri < 4'd12) return ROUND_CONST[ri];
    else return 8'h00;
  endfunction

  function automatic logic [63:0] rotr(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

endpackage

// File: rtl/ascon_round_comb.sv
// One combinational Ascon round: constant addition, bitsliced S-box, linear diffusion.
module ascon_round_comb
  import ascon_pkg::*;
(
  input  logic [319:0] state,
  input  logic [3:0]   ri,
  output logic [319:0] next
);

  ascon_state_t s, l;
  logic [63:0] a0, a1, a2, a3, a4;
  logic [63:0] b0, b1, b2, b3, b4;
  logic [63:0] y0, y1, y2, y3, y4;

  always_comb begin
    s  = unpack_state(state);
    a0 = s.x0 ^ s.x4;
    a1 = s.x1;
    a2 = s.x2 ^ {56'd0, round_const(ri)} ^ s.x1;
    a3 = s.x3;
    a4 = s.x4 ^ s.x3;
    b0 = a0 ^ (~a1 & a2);
    b1 = a1 ^ (~a2 & a3);
    b2 = a2 ^ (~a3 & a4);
    b3 = a3 ^ (~a4 & a0);
    b4 = a4 ^ (~a0 & a1);
    y0 = b0 ^ b4;
    y1 = b1 ^ b0;
    y2 = ~b2;
    y3 = b3 ^ b2;
    y4 = b4;
    l.x0 = y0 ^ rotr(y0, 19) ^ rotr(y0, 28);
    l.x1 = y1 ^ rotr(y1, 61) ^ rotr(y1, 39);
    l.x2 = y2 ^ rotr(y2, 1)  ^ rotr(y2, 6);
    l.x3 = y3 ^ rotr(y3, 10) ^ rotr(y3, 17);
    l.x4 = y4 ^ rotr(y4, 7)  ^ rotr(y4, 41);
    next = pack_state(l);
  end

endmodule

// File: rtl/ascon_perm_core.sv
// Ascon p^a engine applying UNROLL rounds per clock with valid/ready handshakes.
// Optional macro ASCON_PERM_ZEROIZE_EN clears the state register on the output handshake.
module ascon_perm_core
  import ascon_pkg::*;
#(
  parameter int UNROLL     = 1,
  parameter int MAX_ROUNDS = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   in_rounds,
  input  logic [319:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [319:0] out_state,
  output logic         out_err,
  output logic         busy
);

  fsm_state_t   fsm_q, fsm_d;
  logic [319:0] state_q, state_d;
  logic [3:0]   ri_q, ri_d, ri_step;
  logic         err_q, err_d;
  logic         legal;

  logic [319:0] chain [0:UNROLL];

  assign chain[0] = state_q;

  for (genvar g = 0; g < UNROLL; g++) begin : g_round
    ascon_round_comb u_round (
      .state (chain[g]),
      .ri    (ri_q + 4'(g)),
      .next  (chain[g+1])
    );
  end

  assign ri_step = ri_q + 4'(UNROLL);
  assign legal   = (in_rounds != 4'd0) && (in_rounds <= 4'(MAX_ROUNDS))
                   && ((int'(in_rounds) % UNROLL) == 0);

  always_comb begin
    // NOTE: every variable gets a default first, so no path can infer a latch.
    fsm_d   = fsm_q;
    state_d = state_q;
    ri_d    = ri_q;
    err_d   = err_q;
    unique case (fsm_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = in_state;
          if (legal) begin
            ri_d  = 4'(MAX_ROUNDS) - in_rounds;
            fsm_d = ST_RUN;
          end else begin
            ri_d  = 4'(MAX_ROUNDS);
            err_d = 1'b1;
            fsm_d = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        state_d = chain[UNROLL];
        ri_d    = ri_step;
        if (ri_step == 4'(MAX_ROUNDS)) fsm_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          fsm_d = ST_IDLE;
          err_d = 1'b0;
`ifdef ASCON_PERM_ZEROIZE_EN
          state_d = '0;
`else
          state_d = state_q;
`endif
        end
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, avoiding races between flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q   <= ST_IDLE;
      state_q <= '0;
      ri_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      ri_q    <= ri_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (fsm_q == ST_IDLE);
  assign out_valid = (fsm_q == ST_DONE);
  assign out_err   = out_valid & err_q;
  assign busy      = (fsm_q == ST_RUN);
  assign out_state = state_q;

endmodule

// File: tb/tb_ascon_perm_core.sv
// Directed bench for ascon_perm_core with UNROLL=1, 2 and 4 instances against a table-driven model.
module tb_ascon_perm_core;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic [3:0]   in_rounds [3];
  logic [319:0] in_state  [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [319:0] out_state [3];
  logic         out_err   [3];
  logic         busy      [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int UN = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
    ascon_perm_core #(.UNROLL(UN), .MAX_ROUNDS(12)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_rounds (in_rounds[g]),
      .in_state  (in_state[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_state (out_state[g]),
      .out_err   (out_err[g]),
      .busy      (busy[g])
    );
  end

  localparam logic [4:0] SBOX [0:31] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    logic [127:0] d;
    d = {x, x} >> n;
    return d[63:0];
  endfunction

  // Column-wise table lookup; constants derived as 0xf0 - 0x0f*i.
  function automatic logic [319:0] model_perm(input logic [319:0] s, input int a);
    logic [63:0] x [5];
    logic [63:0] y [5];
    logic [4:0]  col, sv;
    logic [7:0]  rc;
    for (int k = 0; k < 5; k++) x[k] = s[319 - 64*k -: 64];
    for (int r = 12 - a; r < 12; r++) begin
      rc = 8'hf0 - 8'(8'h0f * r);
      x[2] = x[2] ^ {56'd0, rc};
      for (int j = 0; j < 64; j++) begin
        col = {x[0][j], x[1][j], x[2][j], x[3][j], x[4][j]};
        sv  = SBOX[col];
        for (int k = 0; k < 5; k++) y[k][j] = sv[4-k];
      end
      x[0] = y[0] ^ ror(y[0], 19) ^ ror(y[0], 28);
      x[1] = y[1] ^ ror(y[1], 61) ^ ror(y[1], 39);
      x[2] = y[2] ^ ror(y[2], 1)  ^ ror(y[2], 6);
      x[3] = y[3] ^ ror(y[3], 10) ^ ror(y[3], 17);
      x[4] = y[4] ^ ror(y[4], 7)  ^ ror(y[4], 41);
    end
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction

  task automatic start_req(input int k, input logic [3:0] a, input logic [319:0] s);
    @(negedge clk);
    check("in_ready_before_accept", in_ready[k], 1'b1);
    in_valid[k]  = 1'b1;
    in_rounds[k] = a;
    in_state[k]  = s;
    @(posedge clk);
    #1;
    in_valid[k]  = 1'b0;
    in_rounds[k] = 4'd0;
    in_state[k]  = ~s;
  endtask

  task automatic wait_out(input int k, output int lat, output int busy_cnt,
                          output logic [319:0] res, output logic err);
    lat      = 0;
    busy_cnt = 0;
    while (!out_valid[k] && lat < 40) begin
      if (busy[k]) busy_cnt++;
      @(posedge clk);
      #1;
      lat++;
    end
    check("out_valid_timeout", out_valid[k], 1'b1);
    res = out_state[k];
    err = out_err[k];
  endtask

  task automatic consume(input int k);
    @(negedge clk);
    out_ready[k] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[k] = 1'b0;
    check("out_valid_after_handshake", out_valid[k], 1'b0);
    check("in_ready_after_handshake", in_ready[k], 1'b1);
  endtask

  task automatic run_req(input int k, input logic [3:0] a, input logic [319:0] s,
                         output int lat, output int busy_cnt,
                         output logic [319:0] res, output logic err);
    start_req(k, a, s);
    wait_out(k, lat, busy_cnt, res, err);
  endtask

  initial begin
    int           lat, bc;
    logic [319:0] res, st;
    logic         err;

    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid[k]  = 1'b0;
      in_rounds[k] = 4'd0;
      in_state[k]  = '0;
      out_ready[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check("reset_in_ready", in_ready[k], 1'b1);
      check("reset_out_valid", out_valid[k], 1'b0);
      check("reset_out_err", out_err[k], 1'b0);
      check("reset_busy", busy[k], 1'b0);
      check("reset_out_state", out_state[k], '0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // p1 on zero state, first word and last word hand-derived.
    run_req(0, 4'd1, '0, lat, bc, res, err);
    check("p1_latency", lat, 1);
    check("p1_err", err, 1'b0);
    check("p1_x0_hand", res[319:256], 64'h000964b00000004b);
    check("p1_x4_hand", res[63:0], 64'h0);
    check("p1_model", res, model_perm('0, 1));
    consume(0);

    // p12 on Ascon-128 IV with zero key and nonce.
    st = {64'h80400c0600000000, 256'd0};
    run_req(0, 4'd12, st, lat, bc, res, err);
    check("p12_latency", lat, 12);
    check("p12_busy_cycles", bc, 12);
    check("p12_err", err, 1'b0);
    check("p12_model", res, model_perm(st, 12));
    consume(0);
`ifdef ASCON_PERM_ZEROIZE_EN
    check("idle_state_after_handshake", out_state[0], '0);
`else
    check("idle_state_after_handshake", out_state[0], model_perm(st, 12));
`endif

    // p6 on UNROLL=2 with a stalled consumer.
    st = {64'h0123456789abcdef, 64'hfedcba9876543210, 64'hdeadbeefcafef00d,
          64'h0f1e2d3c4b5a6978, 64'h5555aaaa3333cccc};
    run_req(1, 4'd6, st, lat, bc, res, err);
    check("p6_u2_latency", lat, 3);
    check("p6_u2_err", err, 1'b0);
    check("p6_u2_model", res, model_perm(st, 6));
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check("stall_out_valid", out_valid[1], 1'b1);
      check("stall_in_ready", in_ready[1], 1'b0);
      check("stall_out_state", out_state[1], model_perm(st, 6));
    end
    consume(1);

    // UNROLL=4 with a count that is not a multiple of 4.
    run_req(2, 4'd6, st, lat, bc, res, err);
    check("illegal_u4_latency", lat, 0);
    check("illegal_u4_err", err, 1'b1);
    check("illegal_u4_state", res, st);
    consume(2);
    run_req(2, 4'd8, st, lat, bc, res, err);
    check("p8_u4_latency", lat, 2);
    check("p8_u4_err", err, 1'b0);
    check("p8_u4_model", res, model_perm(st, 8));
    consume(2);

    // Out-of-range counts on UNROLL=1.
    run_req(0, 4'd0, st, lat, bc, res, err);
    check("rounds0_latency", lat, 0);
    check("rounds0_err", err, 1'b1);
    check("rounds0_state", res, st);
    consume(0);
    run_req(0, 4'd13, st, lat, bc, res, err);
    check("rounds13_err", err, 1'b1);
    consume(0);
    check("err_cleared", out_err[0], 1'b0);

    // Reset in the middle of a p12 run, then a fresh request.
    start_req(0, 4'd12, st);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort_out_valid", out_valid[0], 1'b0);
    check("abort_busy", busy[0], 1'b0);
    check("abort_in_ready", in_ready[0], 1'b1);
    check("abort_out_state", out_state[0], '0);
    @(negedge clk);
    rst_n = 1'b1;
    run_req(0, 4'd8, st, lat, bc, res, err);
    check("post_abort_latency", lat, 8);
    check("post_abort_model", res, model_perm(st, 8));
    consume(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
